// File: rtl/cvp_tb_pkg.sv
// Shared types and helpers for the run/dump sequencer (run_dump_ctrl).
// Holds the controller and reader state encodings and the checksum step.
package cvp_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DUMP     = 3'd4,
        ST_DONE     = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_READ    = 2'd1,
        RD_WAIT    = 2'd2,
        RD_PRESENT = 2'd3
    } rd_state_e;

    // Width of the small phase counter used for reset-hold and drain timing.
    localparam int unsigned PH_W = 16;

    // One checksum step on a w-bit word: rotate left by one, then xor in the data.
    function automatic logic [63:0] chk_step(input logic [63:0] sum,
                                             input logic [63:0] data,
                                             input int unsigned w);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (w >= 32'd64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        s    = sum & mask;
        return (((s << 1) | (s >> (w - 32'd1))) ^ data) & mask;
    endfunction

endpackage

// File: rtl/run_dump_ctrl_if.sv
// Handshake / memory-bus bundle between run_dump_ctrl and its environment.
// master = the sequencer, slave = the bench / system side.
interface run_dump_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 32
);
    logic              Start;
    logic              Halt;
    logic              CpuRst;
    logic              BusOwn;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRD;
    logic [DATA_W-1:0] MemData;
    logic [ADDR_W-1:0] DumpAddr;
    logic [DATA_W-1:0] DumpData;
    logic              DumpValid;
    logic              DumpReady;
    logic [CNT_W-1:0]  CycleCnt;
    logic              Done;
    logic              TimedOut;
    logic [DATA_W-1:0] ExpSum;
    logic [DATA_W-1:0] ChkSum;
    logic              Pass;

    modport master (
        input  Start, Halt, MemData, DumpReady, ExpSum,
        output CpuRst, BusOwn, MemAddr, MemRD, DumpAddr, DumpData, DumpValid,
               CycleCnt, Done, TimedOut, ChkSum, Pass
    );

    modport slave (
        output Start, Halt, MemData, DumpReady, ExpSum,
        input  CpuRst, BusOwn, MemAddr, MemRD, DumpAddr, DumpData, DumpValid,
               CycleCnt, Done, TimedOut, ChkSum, Pass
    );
endinterface

// File: rtl/dump_reader.sv
// Dump reader: issues one read per word, waits RD_LAT cycles using a shift of
// the read strobe, captures the word and presents it until the sink accepts it.
module dump_reader
    import cvp_tb_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       RD_LAT     = 1,
    parameter int unsigned       DUMP_WORDS = 256,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              dump_ready_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_valid_o,
    output logic              last_o
);
    localparam int unsigned IDX_W = (DUMP_WORDS > 32'd1) ? $clog2(DUMP_WORDS) : 32'd1;

    rd_state_e         st_q, st_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              mem_rd_q, mem_rd_d;
    logic              valid_q, valid_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic              hs_s;

    // Next-state: one read per word, hold the presented word until it is accepted.
    always_comb begin
        st_d        = st_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        pipe_d      = (pipe_q << 1) | RD_LAT'(mem_rd_q);
        hs_s        = valid_q & dump_ready_i;
        last_o      = 1'b0;
        case (st_q)
            RD_IDLE: begin
                if (start_i) begin
                    st_d   = RD_READ;
                    idx_d  = '0;
                    addr_d = DUMP_BASE;
                end else begin
                    st_d = RD_IDLE;
                end
            end
            RD_READ: st_d = RD_WAIT;
            RD_WAIT: begin
                if (pipe_q[RD_LAT-1]) begin
                    st_d        = RD_PRESENT;
                    dump_data_d = mem_data_i;
                    dump_addr_d = addr_q;
                end else begin
                    st_d = RD_WAIT;
                end
            end
            RD_PRESENT: begin
                if (hs_s) begin
                    if (idx_q == IDX_W'(DUMP_WORDS - 32'd1)) begin
                        st_d   = RD_IDLE;
                        last_o = 1'b1;
                    end else begin
                        st_d   = RD_READ;
                        idx_d  = idx_q + IDX_W'(1'b1);
                        addr_d = addr_q + ADDR_W'(1'b1);
                    end
                end else begin
                    st_d = RD_PRESENT;
                end
            end
            default: st_d = RD_IDLE;
        endcase
        mem_rd_d = (st_d == RD_READ);
        valid_d  = (st_d == RD_PRESENT);
    end

    // Reader state and registered bus/stream outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q        <= RD_IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            mem_rd_q    <= 1'b0;
            valid_q     <= 1'b0;
            pipe_q      <= '0;
        end else begin
            st_q        <= st_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            mem_rd_q    <= mem_rd_d;
            valid_q     <= valid_d;
            pipe_q      <= pipe_d;
        end
    end

    assign mem_rd_o     = mem_rd_q;
    assign mem_addr_o   = addr_q;
    assign dump_addr_o  = dump_addr_q;
    assign dump_data_o  = dump_data_q;
    assign dump_valid_o = valid_q;
endmodule

// File: rtl/run_dump_ctrl.sv
// Run/dump sequencer: holds the core in reset, runs it until Halt or the cycle
// budget, then owns the memory bus and streams a DRAM window out.
// Optional feature macro: DUMP_CHECKSUM_EN (running checksum, Pass compares to ExpSum).
module run_dump_ctrl
    import cvp_tb_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       CNT_W      = 32,
    parameter int unsigned       RST_CYCLES = 2,
    parameter int unsigned       RUN_CYCLES = 150,
    parameter int unsigned       DRAIN_CYC  = 2,
    parameter int unsigned       RD_LAT     = 1,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
    parameter int unsigned       DUMP_WORDS = 256
) (
    input logic             Clk1,
    input logic             Reset_n,
    run_dump_ctrl_if.master bus
);
    // A zero drain still spends one cycle in DRAIN so the bus hand-over is clean.
    localparam int unsigned DRAIN_LAST = (DRAIN_CYC > 32'd1) ? DRAIN_CYC - 32'd1 : 32'd0;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             timed_q, timed_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             bus_own_q, bus_own_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             dump_start_s;
    logic             rd_last_s;

    // Sequencer next-state: reset hold, run counting, drain, dump, done.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ph_d         = ph_q;
        timed_d      = timed_q;
        dump_start_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    state_d = ST_CORE_RST;
                    cnt_d   = '0;
                    ph_d    = '0;
                    timed_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CORE_RST: begin
                if (ph_q == PH_W'(RST_CYCLES - 32'd1)) begin
                    state_d = ST_RUN;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1'b1);
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1'b1);
                if (bus.Halt || (cnt_q == CNT_W'(RUN_CYCLES - 32'd1))) begin
                    state_d = ST_DRAIN;
                    timed_d = !bus.Halt;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (ph_q == PH_W'(DRAIN_LAST)) begin
                    state_d      = ST_DUMP;
                    dump_start_s = 1'b1;
                    ph_d         = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1'b1);
                end
            end
            ST_DUMP: begin
                if (rd_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DUMP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cpu_rst_d = (state_d != ST_RUN);
        bus_own_d = (state_d == ST_DRAIN) || (state_d == ST_DUMP);
        done_d    = (state_d == ST_DONE);
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    // Fold every accepted word into the checksum; a new Start clears it.
    always_comb begin
        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.Start) begin
            chk_d = '0;
        end else if (bus.DumpValid && bus.DumpReady) begin
            chk_d = DATA_W'(chk_step(64'(chk_q), 64'(bus.DumpData), DATA_W));
        end else begin
            chk_d = chk_q;
        end
        pass_d = done_d && (chk_d == bus.ExpSum);
    end

    // Checksum register.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign bus.ChkSum = chk_q;
`else
    // Without the checksum, a pass means the core halted within budget.
    always_comb begin
        pass_d = done_d && !timed_d;
    end

    assign bus.ChkSum = '0;
`endif

    // Sequencer state, counters and registered status outputs.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ph_q      <= '0;
            timed_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            bus_own_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            timed_q   <= timed_d;
            cpu_rst_q <= cpu_rst_d;
            bus_own_q <= bus_own_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    dump_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .DUMP_WORDS (DUMP_WORDS),
        .DUMP_BASE  (DUMP_BASE)
    ) u_reader (
        .clk_i        (Clk1),
        .rst_ni       (Reset_n),
        .start_i      (dump_start_s),
        .mem_data_i   (bus.MemData),
        .dump_ready_i (bus.DumpReady),
        .mem_rd_o     (bus.MemRD),
        .mem_addr_o   (bus.MemAddr),
        .dump_addr_o  (bus.DumpAddr),
        .dump_data_o  (bus.DumpData),
        .dump_valid_o (bus.DumpValid),
        .last_o       (rd_last_s)
    );

    assign bus.CpuRst   = cpu_rst_q;
    assign bus.BusOwn   = bus_own_q;
    assign bus.CycleCnt = cnt_q;
    assign bus.Done     = done_q;
    assign bus.TimedOut = timed_q;
    assign bus.Pass     = pass_q;
endmodule

// File: tb/tb_run_dump_ctrl.sv
// Bench for run_dump_ctrl: randomized run lengths, sink back-pressure and memory
// contents, checked against a sequence-level reference model.
module tb_run_dump_ctrl;
    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int CW      = 32;
    localparam int RST_C   = 2;
    localparam int RUN_C   = 150;
    localparam int DRAIN_C = 2;
    localparam int LAT     = 2;
    localparam int WORDS   = 4;
    localparam logic [15:0] BASE = 16'hFFFE;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] mp_a [LAT];
    logic          mp_v [LAT];

    run_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    run_dump_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .CNT_W      (CW),
        .RST_CYCLES (RST_C),
        .RUN_CYCLES (RUN_C),
        .DRAIN_CYC  (DRAIN_C),
        .RD_LAT     (LAT),
        .DUMP_BASE  (BASE),
        .DUMP_WORDS (WORDS)
    ) dut (
        .Clk1    (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM model: data appears LAT cycles after the read strobe.
    always @(posedge clk) begin
        mp_a[0] <= bus.MemAddr;
        mp_v[0] <= bus.MemRD;
        for (int i = 1; i < LAT; i++) begin
            mp_a[i] <= mp_a[i-1];
            mp_v[i] <= mp_v[i-1];
        end
    end
    assign bus.MemData = mp_v[LAT-1] ? mem[mp_a[LAT-1]] : 16'hBAD0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_cpurst",   64'(bus.CpuRst),    64'd1);
        check_eq("rst_busown",   64'(bus.BusOwn),    64'd0);
        check_eq("rst_memrd",    64'(bus.MemRD),     64'd0);
        check_eq("rst_valid",    64'(bus.DumpValid), 64'd0);
        check_eq("rst_done",     64'(bus.Done),      64'd0);
        check_eq("rst_timedout", 64'(bus.TimedOut),  64'd0);
        check_eq("rst_pass",     64'(bus.Pass),      64'd0);
        check_eq("rst_cyclecnt", 64'(bus.CycleCnt),  64'd0);
        check_eq("rst_chksum",   64'(bus.ChkSum),    64'd0);
        check_eq("rst_memaddr",  64'(bus.MemAddr),   64'd0);
        check_eq("rst_dumpaddr", 64'(bus.DumpAddr),  64'd0);
        check_eq("rst_dumpdata", 64'(bus.DumpData),  64'd0);
    endtask

    // One full sequence. halt_at: run cycle at which Halt rises (0 = never).
    // rmode: 0 always ready, 1 toggling 1010..., 2 random. abort_after: reset
    // asynchronously while the Nth word is being offered (0 = no abort).
    task automatic run_seq(input int halt_at, input int rmode,
                           input logic [DW-1:0] exp_sum, input int abort_after);
        int w, k, d, cyc, n_hs, n_rd, exp_cyc;
        bit exp_to, stalled, rdy;
        logic [AW-1:0] exp_a, hold_a;
        logic [DW-1:0] exp_chk, hold_d;
        exp_to  = (halt_at < 1) || (halt_at > RUN_C);
        exp_cyc = exp_to ? RUN_C : halt_at;
        exp_chk = '0;
        hold_a  = '0;
        hold_d  = '0;
        bus.ExpSum = exp_sum;
        // Start, with a stray Halt that must be ignored outside RUN.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Halt  = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Halt  = 1'b0;
        check_eq("busown_core_rst", 64'(bus.BusOwn), 64'd0);
        w = 0;
        while (bus.CpuRst && w < 20) begin
            w++;
            @(negedge clk);
        end
        check_eq("core_rst_cycles", 64'(w), 64'(RST_C));
        // Run phase: a stray Start pulse at run cycle 5 must be ignored.
        k = 0;
        while (!bus.CpuRst && k < RUN_C + 10) begin
            k++;
            bus.Start = (k == 5);
            bus.Halt  = (halt_at > 0) && (k >= halt_at);
            @(negedge clk);
        end
        bus.Start = 1'b0;
        bus.Halt  = 1'b1;
        check_eq("run_cycles",   64'(k),            64'(exp_cyc));
        check_eq("cyclecnt",     64'(bus.CycleCnt), 64'(exp_cyc));
        check_eq("timedout",     64'(bus.TimedOut), 64'(exp_to));
        check_eq("busown_drain", 64'(bus.BusOwn),   64'd1);
        d = 0;
        while (!bus.MemRD && d < 20) begin
            d++;
            @(negedge clk);
        end
        bus.Halt = 1'b0;
        check_eq("drain_cycles", 64'(d), 64'(DRAIN_C));
        // Dump phase: scoreboard the stream against the DRAM window.
        cyc = 0; n_hs = 0; n_rd = 0; stalled = 1'b0;
        while (!bus.Done && cyc < 500) begin
            if (bus.MemRD) n_rd++;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.DumpReady = rdy;
            if (bus.DumpValid) begin
                if (stalled) begin
                    check_eq("stall_addr", 64'(bus.DumpAddr), 64'(hold_a));
                    check_eq("stall_data", 64'(bus.DumpData), 64'(hold_d));
                end
                if (rdy) begin
                    exp_a = AW'(32'(BASE) + n_hs);
                    check_eq("dump_addr", 64'(bus.DumpAddr), 64'(exp_a));
                    check_eq("dump_data", 64'(bus.DumpData), 64'(mem[exp_a]));
                    check_eq("busown_dump", 64'(bus.BusOwn), 64'd1);
                    exp_chk = {exp_chk[DW-2:0], exp_chk[DW-1]} ^ mem[exp_a];
                    n_hs++;
                    stalled = 1'b0;
                    if (abort_after > 0 && n_hs == abort_after) begin
                        #2 rst_n = 1'b0;
                        #1 check_reset_vals();
                        @(negedge clk);
                        rst_n = 1'b1;
                        bus.DumpReady = 1'b0;
                        return;
                    end
                end else begin
                    stalled = 1'b1;
                    hold_a  = bus.DumpAddr;
                    hold_d  = bus.DumpData;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("done",           64'(bus.Done),      64'd1);
        check_eq("words_accepted", 64'(n_hs),          64'(WORDS));
        check_eq("reads_issued",   64'(n_rd),          64'(WORDS));
        check_eq("cyclecnt_done",  64'(bus.CycleCnt),  64'(exp_cyc));
        check_eq("timedout_done",  64'(bus.TimedOut),  64'(exp_to));
        check_eq("busown_done",    64'(bus.BusOwn),    64'd0);
        check_eq("cpurst_done",    64'(bus.CpuRst),    64'd1);
        check_eq("valid_done",     64'(bus.DumpValid), 64'd0);
`ifdef DUMP_CHECKSUM_EN
        check_eq("chksum", 64'(bus.ChkSum), 64'(exp_chk));
        check_eq("pass",   64'(bus.Pass),   64'(exp_chk == exp_sum));
`else
        check_eq("chksum", 64'(bus.ChkSum), 64'd0);
        check_eq("pass",   64'(bus.Pass),   64'(!exp_to));
`endif
        bus.DumpReady = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("done_sticky", 64'(bus.Done), 64'd1);
    endtask

    task automatic load_directed();
        for (int i = 0; i < WORDS; i++) mem[AW'(32'(BASE) + i)] = DW'(i + 1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        bus.Start     = 1'b0;
        bus.Halt      = 1'b0;
        bus.DumpReady = 1'b0;
        bus.ExpSum    = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        load_directed();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // Halt at run cycle 40; words 1,2,3,4 give checksum 0x0002.
        run_seq(40, 0, 16'h0002, 0);
        // No Halt: budget expires, toggling sink, mismatching expected sum.
        run_seq(0, 1, 16'h0003, 0);
        // Halt on the last budget cycle: Halt wins the tie.
        run_seq(RUN_C, 2, 16'h0002, 0);
        // Randomized runs over fresh window contents.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < WORDS; i++) mem[AW'(32'(BASE) + i)] = DW'($urandom);
            run_seq(int'($urandom_range(1, RUN_C + 20)), int'($urandom_range(0, 2)),
                    DW'($urandom), 0);
        end
        // Reset in the middle of the dump, then a clean full sequence.
        load_directed();
        run_seq(20, 0, 16'h0002, 2);
        run_seq(35, 2, 16'h0002, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
